// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl: sole GRF writer merging in-order P results with FIFO-buffered long-latency results, plus pending scoreboard
module grf_wb_ctrl #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int DW       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_valid,
    input  logic [4:0]               p_addr,
    input  logic [DW-1:0]            p_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_addr,
    input  logic [DW-1:0]            a_data,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_addr,
    input  logic [4:0]               q_addr1,
    input  logic [4:0]               q_addr2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     drain_stall,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     wb_we,
    output logic [4:0]               wb_a3,
    output logic [DW-1:0]            wb_wd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [4:0]    mem_a [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   pending, pend_set, pend_clr;
    logic          full, empty, push, p_sel, pop, a_wr;
    logic [4:0]    head_a;
    logic [DW-1:0] head_d;

    assign full        = cnt == (AW + 1)'(DEPTH);
    assign empty       = cnt == '0;
    assign a_ready     = !full;
    assign push        = a_valid && !full;
    assign p_sel       = p_valid && p_addr != 5'd0;
    assign pop         = !p_sel && !empty;
    assign head_a      = mem_a[rd_ptr];
    assign head_d      = mem_d[rd_ptr];
    assign a_wr        = pop && head_a != 5'd0;
    assign pend_clr    = pop ? 32'd1 << head_a : 32'd0;
    assign pend_set    = iss_valid ? 32'd1 << iss_addr : 32'd0;
    assign busy1       = q_addr1 != 5'd0 && pending[q_addr1];
    assign busy2       = q_addr2 != 5'd0 && pending[q_addr2];
    assign drain_stall = wait_cnt >= CW'(MAX_WAIT) || full;
    assign fifo_cnt    = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= a_addr;
            mem_d[wr_ptr] <= a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
            pending  <= '0;
            wb_we    <= 1'b0;
            wb_a3    <= 5'd0;
            wb_wd    <= '0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            cnt      <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
            wait_cnt <= (empty || pop) ? '0 : (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
            // set after clear so a same-edge reissue keeps the register pending
            pending  <= ((pending & ~pend_clr) | pend_set) & ~32'd1;
            wb_we    <= p_sel || a_wr;
            if (p_sel) begin
                wb_a3 <= p_addr;
                wb_wd <= p_data;
            end else if (a_wr) begin
                wb_a3 <= head_a;
                wb_wd <= head_d;
            end
        end
    end
endmodule
